// File: rtl/frog.sv
// frog: 4-bit accumulator CPU on a 7-bit multiplexed address/data bus.
// Define FROG_SLOW_MODE_EN to honour io_in[7] (fast=0 stretches every bus cycle to 2 clocks).
module frog (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_OPH   = 3'd1,
        S_OPL   = 3'd2,
        S_RD    = 3'd3,
        S_WA    = 3'd4,
        S_WD    = 3'd5
    } state_t;

    logic       clk;
    logic       rst_p;
    logic [3:0] data;

    assign clk   = io_in[0];
    assign rst_p = io_in[1];
    assign data  = io_in[5:2];

    state_t     state_q, state_d;
    logic [6:0] pc_q, pc_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] hi_q, hi_d;
    logic [3:0] lo_q, lo_d;
    logic [3:0] op_q, op_d;
    logic       hold_q, hold_d;
    logic       advance;
    logic       taken;
    logic [6:0] addr;
    logic [6:0] br_addr;

    // A bus cycle ends on an advancing edge; slow cycles spend one extra edge in hold.
`ifdef FROG_SLOW_MODE_EN
    logic unused_bits;
    assign unused_bits = ^{io_in[6], hi_q[3]};
    assign advance     = io_in[7] | hold_q;
`else
    logic unused_bits;
    assign unused_bits = ^{io_in[7:6], hi_q[3]};
    assign advance     = 1'b1;
`endif
    assign hold_d = ~advance;

    assign addr    = {hi_q[2:0], lo_q};
    assign br_addr = {hi_q[2:0], data};

    always_comb begin
        taken = 1'b0;
        case (op_q)
            4'h9:    taken = (a_q == b_q);
            4'hA:    taken = (a_q <= b_q);
            4'hB:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    function automatic logic [3:0] alu(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
        logic [3:0] r;
        case (op)
            4'h0:    r = ~a + 4'd1;
            4'h1:    r = a & b;
            4'h2:    r = a | b;
            4'h3:    r = a ^ b;
            4'h4:    r = {a[2:0], 1'b0};
            4'h5:    r = {1'b0, a[3:1]};
            4'h6:    r = {a[3], a[3:1]};
            4'h7:    r = a + b;
            default: r = a;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH: begin
                op_d = data;
                pc_d = pc_q + 7'd1;
                if (data > 4'h8) state_d = S_OPH;
                else             a_d     = alu(data, a_q, b_q);
            end
            S_OPH: begin
                hi_d    = data;
                pc_d    = pc_q + 7'd1;
                state_d = S_OPL;
            end
            S_OPL: begin
                lo_d = data;
                pc_d = taken ? br_addr : pc_q + 7'd1;
                case (op_q)
                    4'hC, 4'hD: state_d = S_RD;
                    4'hE, 4'hF: state_d = S_WA;
                    default:    state_d = S_FETCH;
                endcase
            end
            S_RD: begin
                if (op_q[0]) b_d = data;
                else         a_d = data;
                state_d = S_FETCH;
            end
            S_WA:    state_d = S_WD;
            S_WD:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q <= S_FETCH;
            pc_q    <= 7'd0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            hi_q    <= 4'd0;
            lo_q    <= 4'd0;
            op_q    <= 4'd0;
            hold_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            if (advance) begin
                state_q <= state_d;
                pc_q    <= pc_d;
                a_q     <= a_d;
                b_q     <= b_d;
                hi_q    <= hi_d;
                lo_q    <= lo_d;
                op_q    <= op_d;
            end
        end
    end

    // Bus driven from registers only, so it is stable for the whole bus cycle.
    always_comb begin
        io_out = {1'b0, pc_q};
        case (state_q)
            S_RD, S_WA: io_out = {1'b0, addr};
            S_WD:       io_out = {1'b1, 3'b000, (op_q[0] ? b_q : a_q)};
            default:    io_out = {1'b0, pc_q};
        endcase
    end
endmodule

// File: tb/tb_frog.sv
// Directed bench for frog: nibble memory model on the bus, scoreboard queue of expected bus values.
module tb_frog;
    logic       clk = 1'b0;
    logic       rst_p;
    logic       fast;
    logic [3:0] data;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {fast, 1'b0, data, rst_p, clk};

    frog dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] out;
        logic       ck;
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    exp_t       q[$];
    logic [3:0] mem[128];
    logic [6:0] wa;
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %02h want %02h", tag, obs, expv);
        end
    endtask

    // One clock: memory write on WD, WA address capture, read data set at the negedge.
    task automatic cyc();
        logic [7:0] o;
        o = io_out;
        @(posedge clk);
        if (o[7]) mem[wa] = o[3:0];
        else      wa = o[6:0];
        @(negedge clk);
        data = mem[io_out[6:0]];
    endtask

    task automatic ex(input string tag, input logic [7:0] out);
        exp_t e;
        e.tag = tag; e.out = out; e.ck = 1'b0; e.a = 4'd0; e.b = 4'd0;
        q.push_back(e);
    endtask

    task automatic exab(input string tag, input logic [7:0] out, input logic [3:0] a,
                        input logic [3:0] b);
        exp_t e;
        e.tag = tag; e.out = out; e.ck = 1'b1; e.a = a; e.b = b;
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, io_out, e.out);
            if (e.ck) begin
                chk({e.tag, ".a"}, {4'h0, dut.a_q}, {4'h0, e.a});
                chk({e.tag, ".b"}, {4'h0, dut.b_q}, {4'h0, e.b});
            end
            cyc();
        end
    endtask

    task automatic fill(input logic [3:0] f);
        for (int i = 0; i < 128; i++) mem[i] = f;
    endtask

    task automatic prog(input logic [6:0] base, input string s);
        logic [6:0] ad;
        int         v;
        ad = base;
        for (int i = 0; i < s.len(); i++) begin
            v = int'(s.getc(i));
            v = (v >= 65) ? v - 55 : v - 48;
            mem[ad] = v[3:0];
            ad = ad + 7'd1;
        end
    endtask

    task automatic do_reset();
        rst_p = 1'b1;
        cyc();
        cyc();
        chk("reset_out", io_out, 8'h00);
        chk("reset_a", {4'h0, dut.a_q}, 8'h00);
        rst_p = 1'b0;
    endtask

    initial begin
        rst_p = 1'b1;
        fast  = 1'b1;
        data  = 4'h0;
        wa    = 7'd0;

        // All-NOP walk with PC wrap.
        fill(4'h8);
        do_reset();
        for (int i = 0; i < 130; i++) ex("nop_walk", 8'(i % 128));
        drain();

        // LDA/LDB then ALU chain, then STA/STB.
        fill(4'h8);
        prog(7'h02, "C0DD09B10");
        mem[7'h0D] = 4'h5;
        prog(7'h10, "10145464237");
        prog(7'h1B, "E30F31");
        do_reset();
        ex("ld_f0", 8'h00); ex("ld_f1", 8'h01); ex("lda_f", 8'h02); ex("lda_h", 8'h03);
        ex("lda_l", 8'h04); ex("lda_rd", 8'h0D);
        exab("ldb_f", 8'h05, 4'h5, 4'h0); ex("ldb_h", 8'h06); ex("ldb_l", 8'h07);
        ex("ldb_rd", 8'h09);
        exab("jmp_f", 8'h08, 4'h5, 4'h1); ex("jmp_h", 8'h09); ex("jmp_l", 8'h0A);
        ex("and1", 8'h10);
        exab("nga", 8'h11, 4'h1, 4'h1); exab("and2", 8'h12, 4'hF, 4'h1);
        exab("sll1", 8'h13, 4'h1, 4'h1); exab("srl1", 8'h14, 4'h2, 4'h1);
        exab("sll2", 8'h15, 4'h1, 4'h1); exab("sra1", 8'h16, 4'h2, 4'h1);
        exab("sll3", 8'h17, 4'h1, 4'h1); exab("or", 8'h18, 4'h2, 4'h1);
        exab("xor", 8'h19, 4'h3, 4'h1); exab("add", 8'h1A, 4'h2, 4'h1);
        exab("sta_f", 8'h1B, 4'h3, 4'h1); ex("sta_h", 8'h1C); ex("sta_l", 8'h1D);
        ex("sta_wa", 8'h30); ex("sta_wd", 8'h83);
        ex("stb_f", 8'h1E); ex("stb_h", 8'h1F); ex("stb_l", 8'h20);
        ex("stb_wa", 8'h31); ex("stb_wd", 8'h81); ex("after_st", 8'h21);
        drain();
        chk("mem30", {4'h0, mem[7'h30]}, 8'h03);
        chk("mem31", {4'h0, mem[7'h31]}, 8'h01);

        // SRA sign fill and SRL zero fill on 0xA.
        fill(4'h8);
        prog(7'h00, "C406C405E41");
        mem[7'h40] = 4'hA;
        do_reset();
        ex("s_f0", 8'h00); ex("s_h0", 8'h01); ex("s_l0", 8'h02); ex("s_rd0", 8'h40);
        ex("sra_f", 8'h03);
        exab("sra_res", 8'h04, 4'hD, 4'h0); ex("s_h1", 8'h05); ex("s_l1", 8'h06);
        ex("s_rd1", 8'h40); ex("srl_f", 8'h07);
        exab("srl_res", 8'h08, 4'h5, 4'h0); ex("s_h2", 8'h09); ex("s_l2", 8'h0A);
        ex("s_wa", 8'h41); ex("s_wd", 8'h85); ex("s_next", 8'h0B);
        drain();
        chk("mem41", {4'h0, mem[7'h41]}, 8'h05);

        // Branches: fall-through, BEQ taken, JMP, BLE taken with HI[3] set.
        fill(4'h8);
        prog(7'h00, "C40D41902A02C41920");
        prog(7'h20, "B30");
        prog(7'h30, "AFE");
        mem[7'h40] = 4'h3;
        mem[7'h41] = 4'h1;
        do_reset();
        ex("b_f0", 8'h00); ex("b_h0", 8'h01); ex("b_l0", 8'h02); ex("b_rd0", 8'h40);
        ex("b_f1", 8'h03); ex("b_h1", 8'h04); ex("b_l1", 8'h05); ex("b_rd1", 8'h41);
        exab("beq_nt_f", 8'h06, 4'h3, 4'h1); ex("beq_nt_h", 8'h07); ex("beq_nt_l", 8'h08);
        ex("ble_nt_f", 8'h09); ex("ble_nt_h", 8'h0A); ex("ble_nt_l", 8'h0B);
        ex("b_f2", 8'h0C); ex("b_h2", 8'h0D); ex("b_l2", 8'h0E); ex("b_rd2", 8'h41);
        exab("beq_t_f", 8'h0F, 4'h1, 4'h1); ex("beq_t_h", 8'h10); ex("beq_t_l", 8'h11);
        ex("jmp_f", 8'h20); ex("jmp_h", 8'h21); ex("jmp_l", 8'h22);
        ex("ble_t_f", 8'h30); ex("ble_t_h", 8'h31); ex("ble_t_l", 8'h32);
        ex("ble_tgt", 8'h7E); ex("ble_tgt1", 8'h7F); ex("wrap", 8'h00);
        drain();

        // fast=0 (stretched only when slow mode is compiled in), then reset during OPL.
        fill(4'h8);
        prog(7'h00, "C40D41C40");
        mem[7'h40] = 4'h3;
        mem[7'h41] = 4'h1;
        fast = 1'b0;
        do_reset();
`ifdef FROG_SLOW_MODE_EN
        ex("sl_f0a", 8'h00); ex("sl_f0b", 8'h00); ex("sl_h0a", 8'h01); ex("sl_h0b", 8'h01);
        ex("sl_l0a", 8'h02); ex("sl_l0b", 8'h02); ex("sl_rda", 8'h40); ex("sl_rdb", 8'h40);
        exab("sl_f1a", 8'h03, 4'h3, 4'h0); ex("sl_f1b", 8'h03);
`else
        ex("sl_f0", 8'h00); ex("sl_h0", 8'h01); ex("sl_l0", 8'h02); ex("sl_rd", 8'h40);
        exab("sl_f1", 8'h03, 4'h3, 4'h0);
`endif
        drain();
        fast = 1'b1;
        ex("r_h1", 8'h04); ex("r_l1", 8'h05); ex("r_rd1", 8'h41);
        exab("r_f2", 8'h06, 4'h3, 4'h1); ex("r_h2", 8'h07);
        drain();
        chk("r_opl", io_out, 8'h08);
        rst_p = 1'b1;
        cyc();
        chk("r_mid_out", io_out, 8'h00);
        chk("r_mid_a", {4'h0, dut.a_q}, 8'h00);
        chk("r_mid_b", {4'h0, dut.b_q}, 8'h00);
        rst_p = 1'b0;
        ex("r_after0", 8'h00); ex("r_after1", 8'h01);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
